// File: rtl/ederah_axi_mem_responder_if.sv
// AXI4 write/read channel bundle between a burst master and the memory responder.
`timescale 1ns/1ps
interface ederah_axi_mem_responder_if #(
    parameter int AW = 64,
    parameter int DW = 512
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            bvalid;
    logic            bready;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic            rlast;

    modport slave (
        input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, rready,
        output awready, wready, bvalid, arready, rvalid, rdata, rlast
    );

    modport master (
        output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata, rlast
    );
endinterface

// File: rtl/ederah_axi_mem_responder.sv
// AXI4 INCR-burst memory responder over an internal word RAM, with burst counters.
// Latency: first read beat 2 cycles after AR handshake; B 1 cycle after last W beat.
// Backpressure: 2-entry read buffer holds rdata stable under rready=0; W/AW/AR one burst at a time.
`timescale 1ns/1ps
module ederah_axi_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_LOG2   = 10
) (
    input  logic                             data_clk,
    input  logic                             data_rst_n,
    ederah_axi_mem_responder_if.slave        s_axi,
    output logic                             proto_err_o,
    output logic [31:0]                      wr_bursts_o,
    output logic [31:0]                      rd_bursts_o
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int LSB   = $clog2(SW);
    localparam int DL    = C_MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << DL;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

    logic [DW-1:0] mem [DEPTH];

    // Holds address ready low until the first edge after reset release.
    logic alive;

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) alive <= 1'b0;
        else             alive <= 1'b1;
    end

    // ---------------- write channel ----------------
    w_state_t      w_state, w_state_nxt;
    logic [DL-1:0] w_base;
    logic [7:0]    w_len, w_beat;
    logic [DL-1:0] w_idx;
    logic          aw_hs, w_hs, b_hs, w_is_last;

    assign w_idx     = w_base + DL'(w_beat);
    assign w_is_last = (w_beat == w_len);
    assign aw_hs     = s_axi.awvalid && s_axi.awready;
    assign w_hs      = s_axi.wvalid && s_axi.wready;
    assign b_hs      = s_axi.bvalid && s_axi.bready;

    always_comb begin
        w_state_nxt   = w_state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi.awready = alive;
                if (s_axi.awvalid && alive) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && w_is_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            w_state     <= W_IDLE;
            w_base      <= '0;
            w_len       <= '0;
            w_beat      <= '0;
            proto_err_o <= 1'b0;
            wr_bursts_o <= '0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_base <= s_axi.awaddr[LSB +: DL];
                w_len  <= s_axi.awlen;
                w_beat <= '0;
            end
            if (w_hs) begin
                w_beat <= w_beat + 8'd1;
                // Length always follows awlen; a misplaced wlast is only flagged.
                if (s_axi.wlast != w_is_last) proto_err_o <= 1'b1;
            end
            if (b_hs) wr_bursts_o <= wr_bursts_o + 32'd1;
        end
    end

    always_ff @(posedge data_clk) begin
        if (w_hs) begin
            for (int b = 0; b < SW; b++) begin
                if (s_axi.wstrb[b]) mem[w_idx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t      r_state, r_state_nxt;
    logic [DL-1:0] r_base;
    logic [7:0]    r_len, r_beat;
    logic [DL-1:0] r_idx;
    logic          r_fetch_done;
    logic          ar_hs, r_hs, fetch;

    // The RAM read lands straight in a buffer slot, so the slot counts as in flight.
    logic [DW-1:0] buf_dat [2];
    logic          buf_last [2];
    logic          buf_wp, buf_rp;
    logic [1:0]    buf_cnt;

    assign r_idx = r_base + DL'(r_beat);
    assign ar_hs = s_axi.arvalid && s_axi.arready;
    assign r_hs  = s_axi.rvalid && s_axi.rready;
    assign fetch = (r_state == R_BURST) && !r_fetch_done && (buf_cnt != 2'd2);

    always_comb begin
        r_state_nxt   = r_state;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = (buf_cnt != 2'd0);
        s_axi.rdata   = s_axi.rvalid ? buf_dat[buf_rp] : '0;
        s_axi.rlast   = s_axi.rvalid && buf_last[buf_rp];
        case (r_state)
            R_IDLE: begin
                s_axi.arready = alive;
                if (s_axi.arvalid && alive) r_state_nxt = R_BURST;
            end
            R_BURST: begin
                if (s_axi.rvalid && s_axi.rready && s_axi.rlast) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_state      <= R_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_beat       <= '0;
            r_fetch_done <= 1'b0;
            buf_wp       <= 1'b0;
            buf_rp       <= 1'b0;
            buf_cnt      <= '0;
            rd_bursts_o  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_base       <= s_axi.araddr[LSB +: DL];
                r_len        <= s_axi.arlen;
                r_beat       <= '0;
                r_fetch_done <= 1'b0;
            end
            if (fetch) begin
                buf_wp <= ~buf_wp;
                r_beat <= r_beat + 8'd1;
                if (r_beat == r_len) r_fetch_done <= 1'b1;
            end
            if (r_hs) begin
                buf_rp <= ~buf_rp;
                if (s_axi.rlast) rd_bursts_o <= rd_bursts_o + 32'd1;
            end
            buf_cnt <= buf_cnt + {1'b0, fetch} - {1'b0, r_hs};
        end
    end

    always_ff @(posedge data_clk) begin
        if (fetch) begin
            buf_dat[buf_wp]  <= mem[r_idx];
            buf_last[buf_wp] <= (r_beat == r_len);
        end
    end
endmodule

// File: tb/tb_ederah_axi_mem_responder.sv
// Directed bench for the AXI memory responder: word-level memory model plus expected-beat queue.
`timescale 1ns/1ps
module tb_ederah_axi_mem_responder;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic        data_clk = 1'b0;
    logic        data_rst_n = 1'b0;
    logic        proto_err_o;
    logic [31:0] wr_bursts_o, rd_bursts_o;

    ederah_axi_mem_responder_if #(.AW(AW), .DW(DW)) ifc ();

    ederah_axi_mem_responder #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .C_MEM_DEPTH_LOG2  (DL)
    ) dut (
        .data_clk   (data_clk),
        .data_rst_n (data_rst_n),
        .s_axi      (ifc),
        .proto_err_o(proto_err_o),
        .wr_bursts_o(wr_bursts_o),
        .rd_bursts_o(rd_bursts_o)
    );

    always #5 data_clk = ~data_clk;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge data_clk) cyc <= cyc + 1;

    logic [63:0] mdl [DEPTH];
    logic [63:0] exp_d [$];
    logic        exp_l [$];
    int          exp_wr = 0;
    int          exp_rd = 0;
    bit          mon_en = 1'b0;
    int          last_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Wait for ready/valid on one channel, then return just after the consuming edge.
    task automatic hs_wait(input int which, input string nm);
        int  n = 0;
        bit  got = 1'b0;
        while (!got && n < 200) begin
            @(negedge data_clk);
            case (which)
                0:       got = ifc.awready;
                1:       got = ifc.wready;
                2:       got = ifc.bvalid;
                default: got = ifc.arready;
            endcase
            n++;
        end
        if (!got) begin
            checks++;
            errs++;
            $display("FAIL timeout_%s: got no handshake want handshake within 200 cycles", nm);
        end
        @(posedge data_clk);
        #1;
    endtask

    task automatic wr_burst(input logic [AW-1:0] addr, input int len, input logic [63:0] seed,
                            input logic [7:0] strb, input int last_at);
        int base = int'((addr >> 3) % DEPTH);
        ifc.awvalid = 1'b1;
        ifc.awaddr  = addr;
        ifc.awlen   = 8'(len);
        hs_wait(0, "aw");
        ifc.awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            logic [63:0] d;
            int i;
            d = seed + 64'(n);
            i = (base + n) % DEPTH;
            ifc.wvalid = 1'b1;
            ifc.wdata  = d;
            ifc.wstrb  = strb;
            ifc.wlast  = (n == last_at);
            hs_wait(1, "w");
            for (int b = 0; b < 8; b++)
                if (strb[b]) mdl[i][8*b +: 8] = d[8*b +: 8];
        end
        ifc.wvalid = 1'b0;
        ifc.wlast  = 1'b0;
        chk("b_after_last_w", ifc.bvalid, 1);
        ifc.bready = 1'b1;
        hs_wait(2, "b");
        ifc.bready = 1'b0;
        exp_wr++;
        chk("wr_bursts", wr_bursts_o, exp_wr);
    endtask

    task automatic rd_burst(input logic [AW-1:0] addr, input int len, input bit rnd,
                            input logic [63:0] exp_first);
        int base = int'((addr >> 3) % DEPTH);
        int first_cyc;
        int guard = 0;
        for (int n = 0; n <= len; n++) begin
            exp_d.push_back(mdl[(base + n) % DEPTH]);
            exp_l.push_back(n == len);
        end
        ifc.rready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ifc.arvalid = 1'b1;
        ifc.araddr  = addr;
        ifc.arlen   = 8'(len);
        hs_wait(3, "ar");
        ifc.arvalid = 1'b0;
        @(negedge data_clk);
        chk("rd_lat_t1_idle", ifc.rvalid, 0);
        @(posedge data_clk);
        #1;
        if (rnd) ifc.rready = 1'($urandom_range(0, 1));
        @(negedge data_clk);
        chk("rd_lat_t2_vld", ifc.rvalid, 1);
        chk("rd_first_data", ifc.rdata, exp_first);
        first_cyc = cyc;
        while (exp_d.size() != 0 && guard < 600) begin
            @(posedge data_clk);
            #1;
            if (rnd) ifc.rready = 1'($urandom_range(0, 1));
            guard++;
        end
        if (exp_d.size() != 0) begin
            checks++;
            errs++;
            $display("FAIL rd_timeout: got %0d beats left want 0", exp_d.size());
            exp_d.delete();
            exp_l.delete();
        end
        ifc.rready = 1'b0;
        exp_rd++;
        chk("rd_bursts", rd_bursts_o, exp_rd);
        if (!rnd) chk("rd_back_to_back", last_cyc - first_cyc, len);
    endtask

    // Every cycle with rvalid: compare against the head of the expected-beat queue and
    // verify that a stalled beat does not change.
    bit          stall_prev = 1'b0;
    logic [63:0] hold_dat;
    logic        hold_last;
    always @(negedge data_clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                chk("r_hold_vld", ifc.rvalid, 1);
                chk("r_hold_dat", ifc.rdata, hold_dat);
                chk("r_hold_last", ifc.rlast, hold_last);
            end
            if (ifc.rvalid) begin
                if (exp_d.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL r_extra_beat: got rvalid with data %h want no beat", ifc.rdata);
                end else begin
                    chk("r_data", ifc.rdata, exp_d[0]);
                    chk("r_last", ifc.rlast, exp_l[0]);
                    if (ifc.rready) begin
                        if (ifc.rlast) last_cyc = cyc;
                        void'(exp_d.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
            stall_prev = ifc.rvalid && !ifc.rready;
            hold_dat   = ifc.rdata;
            hold_last  = ifc.rlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.awvalid = 0; ifc.awaddr = '0; ifc.awlen = '0;
        ifc.wvalid = 0; ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 0;
        ifc.bready = 0; ifc.arvalid = 0; ifc.araddr = '0; ifc.arlen = '0; ifc.rready = 0;

        // reset state
        repeat (3) @(posedge data_clk);
        @(negedge data_clk);
        chk("rst_awready", ifc.awready, 0);
        chk("rst_arready", ifc.arready, 0);
        chk("rst_wready", ifc.wready, 0);
        chk("rst_bvalid", ifc.bvalid, 0);
        chk("rst_rvalid", ifc.rvalid, 0);
        chk("rst_rdata", ifc.rdata, 0);
        chk("rst_proto", proto_err_o, 0);
        chk("rst_wr_cnt", wr_bursts_o, 0);
        chk("rst_rd_cnt", rd_bursts_o, 0);
        data_rst_n = 1'b1;
        @(posedge data_clk);
        #1;
        chk("post_rst_awready", ifc.awready, 1);
        chk("post_rst_arready", ifc.arready, 1);
        mon_en = 1'b1;

        // basic 4-beat write then back-to-back readback
        wr_burst(32'h0, 3, 64'hA5A5_0000_0000_0000, 8'hFF, 3);
        chk("mdl_pin_a2", mdl[2], 64'hA5A5_0000_0000_0002);
        chk("wr_cnt_one", wr_bursts_o, 32'd1);
        chk("proto_clean", proto_err_o, 0);
        rd_burst(32'h0, 3, 1'b0, 64'hA5A5_0000_0000_0000);
        chk("rd_cnt_one", rd_bursts_o, 32'd1);

        // 16-beat write wrapping the RAM, random-backpressure read
        wr_burst(32'h20, 15, 64'hC3C3_0000_0000_0000, 8'hFF, 15);
        chk("mdl_pin_c0", mdl[0], 64'hC3C3_0000_0000_000C);
        rd_burst(32'h0, 15, 1'b1, 64'hC3C3_0000_0000_000C);

        // partial strobe over all-ones
        wr_burst(32'h28, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        wr_burst(32'h28, 0, 64'h1234_5678_9ABC_DEF0, 8'h0F, 0);
        chk("mdl_pin_strb", mdl[5], 64'hFFFF_FFFF_9ABC_DEF0);
        rd_burst(32'h28, 0, 1'b0, 64'hFFFF_FFFF_9ABC_DEF0);

        // burst starting two words below the top wraps to index 0
        wr_burst(32'h70, 3, 64'h7E7E_0000_0000_0000, 8'hFF, 3);
        rd_burst(32'h0, 1, 1'b0, 64'h7E7E_0000_0000_0002);
        rd_burst(32'h70, 3, 1'b0, 64'h7E7E_0000_0000_0000);

        // early wlast on an unaligned burst: flagged, length still from awlen
        chk("proto_before", proto_err_o, 0);
        wr_burst(32'h43, 3, 64'hDEAD_0000_0000_0000, 8'hFF, 1);
        chk("proto_set", proto_err_o, 1);
        rd_burst(32'h40, 3, 1'b1, 64'hDEAD_0000_0000_0000);
        chk("proto_sticky", proto_err_o, 1);

        // reset in the middle of a stalled read
        mon_en = 1'b0;
        ifc.rready  = 1'b0;
        ifc.arvalid = 1'b1;
        ifc.araddr  = 32'h0;
        ifc.arlen   = 8'd15;
        hs_wait(3, "ar_rst");
        ifc.arvalid = 1'b0;
        repeat (3) @(posedge data_clk);
        #1;
        chk("pre_rst_rvalid", ifc.rvalid, 1);
        #2;
        data_rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", ifc.rvalid, 0);
        chk("midrst_rlast", ifc.rlast, 0);
        chk("midrst_arready", ifc.arready, 0);
        chk("midrst_proto", proto_err_o, 0);
        chk("midrst_wr_cnt", wr_bursts_o, 0);
        chk("midrst_rd_cnt", rd_bursts_o, 0);
        repeat (2) @(posedge data_clk);
        #2;
        data_rst_n = 1'b1;
        @(posedge data_clk);
        #1;
        chk("rel_arready", ifc.arready, 1);
        chk("rel_awready", ifc.awready, 1);
        exp_wr = 0;
        exp_rd = 0;
        mon_en = 1'b1;

        // RAM contents survive reset
        rd_burst(32'h0, 1, 1'b0, 64'h7E7E_0000_0000_0002);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
